// File: rtl/ram_2port.sv
// Simple dual-port RAM: one synchronous write port and one read port whose
// data is registered, so read_data follows read_addr by one clock.
module ram_2port #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

  // write port
  always_ff @(posedge clk) begin
    if (write_en) begin
      r_mem[write_addr] <= write_data;
    end
  end

  // registered read port; contents and read register are intentionally not reset
  always_ff @(posedge clk) begin
    if (read_en) begin
      read_data <= r_mem[read_addr];
    end
  end

endmodule

// File: rtl/ram_fifo.sv
// RAM-backed FIFO with a 2-entry output buffer so the head is registered and
// a full-rate stream survives the one-cycle RAM read latency.
module ram_fifo #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] count
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_ram_cnt;
  logic                  r_rd_pending;
  logic [1:0]            r_ob_cnt;
  logic [DATA_WIDTH-1:0] r_ob0;
  logic [DATA_WIDTH-1:0] r_ob1;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic [2:0]            w_ob_base;
  logic [2:0]            w_ob_after;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] w_ob0_n;
  logic [DATA_WIDTH-1:0] w_ob1_n;
  logic [ADDR_WIDTH:0]   w_ram_cnt_n;

  assign in_ready  = rst_n && (r_ram_cnt < DEPTH_C);
  assign out_valid = (r_ob_cnt != 2'd0);
  assign out_data  = r_ob0;
  assign count     = (ADDR_WIDTH+2)'(r_ram_cnt) + (ADDR_WIDTH+2)'(r_rd_pending)
                   + (ADDR_WIDTH+2)'(r_ob_cnt);

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // w_ob_base is the slot an arriving read lands in; issue only if a slot stays free for it
  assign w_ob_base   = {1'b0, r_ob_cnt} - {2'b00, w_pop};
  assign w_ob_after  = w_ob_base + {2'b00, r_rd_pending};
  assign w_issue     = (r_ram_cnt != '0) && (w_ob_after < 3'd2);
  assign w_ram_cnt_n = r_ram_cnt + (ADDR_WIDTH+1)'(w_push) - (ADDR_WIDTH+1)'(w_issue);

  ram_2port #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk        (clk),
    .write_en   (w_push),
    .write_addr (r_wr_ptr),
    .write_data (in_data),
    .read_en    (w_issue),
    .read_addr  (r_rd_ptr),
    .read_data  (w_rd_data)
  );

  // output buffer next state: shift on pop, then append the returning read
  always_comb begin
    w_ob0_n = r_ob0;
    w_ob1_n = r_ob1;
    if (w_pop) begin
      w_ob0_n = r_ob1;
    end else begin
      w_ob0_n = r_ob0;
    end
    if (r_rd_pending) begin
      case (w_ob_base[1:0])
        2'd0:    w_ob0_n = w_rd_data;
        2'd1:    w_ob1_n = w_rd_data;
        default: w_ob1_n = r_ob1;
      endcase
    end else begin
      w_ob1_n = r_ob1;
    end
  end

  // pointers, occupancy and buffer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_ram_cnt    <= '0;
      r_rd_pending <= 1'b0;
      r_ob_cnt     <= 2'd0;
      r_ob0        <= '0;
      r_ob1        <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      r_ram_cnt    <= w_ram_cnt_n;
      r_rd_pending <= w_issue;
      r_ob_cnt     <= w_ob_after[1:0];
      r_ob0        <= w_ob0_n;
      r_ob1        <= w_ob1_n;
    end
  end

endmodule

// File: tb/tb_ram_fifo.sv
// Directed self-checking bench for ram_fifo with a queue scoreboard.
module tb_ram_fifo;

  localparam int AW = 6;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW+1:0] count;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  ram_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pop everything held, comparing against the scoreboard
  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check({tag, "_extra"}, 64'(out_valid), 64'd0);
        end else begin
          check({tag, "_data"}, 64'(out_data), 64'(sb.pop_front()));
        end
      end
      tick();
      if (sb.size() == 0 && !out_valid) break;
    end
    out_ready = 1'b0;
    check({tag, "_left"}, 64'(sb.size()), 64'd0);
    check({tag, "_count"}, 64'(count), 64'd0);
  endtask

  initial begin
    int exp_idx;
    int drops;
    int acc;
    logic [DW-1:0] held;
    logic          held_v;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick(); tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // basic latency: push at edge 0, visible after edge 2
    in_valid = 1'b1; in_data = 64'hA5;
    tick();
    in_valid = 1'b0;
    check("lat_e0_valid", 64'(out_valid), 64'd0);
    check("lat_e0_count", 64'(count), 64'd1);
    tick();
    check("lat_e1_valid", 64'(out_valid), 64'd0);
    tick();
    check("lat_e2_valid", 64'(out_valid), 64'd1);
    check("lat_e2_data", 64'(out_data), 64'hA5);
    check("lat_e2_count", 64'(count), 64'd1);
    tick(); tick();
    check("lat_stall_data", 64'(out_data), 64'hA5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("lat_pop_valid", 64'(out_valid), 64'd0);
    check("lat_pop_count", 64'(count), 64'd0);

    // streaming: push k at edge k, value v seen before edge v+3 and popped there
    exp_idx = 0; drops = 0;
    for (int k = 0; k < 110; k++) begin
      in_valid  = (k < 100);
      in_data   = 64'(k);
      out_ready = 1'b1;
      if (k < 100 && !in_ready) drops++;
      if (out_valid) begin
        check("stream_data", 64'(out_data), 64'(exp_idx));
        check("stream_slot", 64'(k), 64'(exp_idx + 3));
        exp_idx++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("stream_drops", 64'(drops), 64'd0);
    check("stream_total", 64'(exp_idx), 64'd100);
    check("stream_count", 64'(count), 64'd0);

    // fill: 64 RAM entries plus 2 in the output buffer
    acc = 0;
    for (int k = 0; k < 70; k++) begin
      in_valid = 1'b1;
      in_data  = 64'(500 + k);
      if (in_ready) begin
        sb.push_back(64'(500 + k));
        acc++;
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("fill_accepted", 64'(acc), 64'd66);
    check("fill_count", 64'(count), 64'd66);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    check("fill_head", 64'(out_data), 64'd500);
    out_ready = 1'b1;
    check("fill_pop_data", 64'(out_data), 64'(sb.pop_front()));
    tick();
    out_ready = 1'b0;
    check("fill_ready_back", 64'(in_ready), 64'd1);
    check("fill_count_pop", 64'(count), 64'd65);
    drain("fill_drain");

    // random backpressure across many pointer wraps
    held_v = 1'b0; held = '0;
    for (int k = 0; k < 3000; k++) begin
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 1) == 1;
      in_data   = {$urandom, $urandom};
      check("bp_count", 64'(count), 64'(sb.size()));
      if (held_v && out_valid) check("bp_stable", 64'(out_data), 64'(held));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("bp_extra", 64'(out_valid), 64'd0);
        else check("bp_data", 64'(out_data), 64'(sb.pop_front()));
      end
      if (in_valid && in_ready) sb.push_back(in_data);
      held_v = out_valid && !out_ready;
      held   = out_data;
      tick();
    end
    drain("bp_drain");

    // mid-operation reset with a read in flight
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = 64'(16'hBEE0 + k);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("mr_count_held", 64'(count), 64'd10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("mr_count_pending", 64'(count), 64'd9);
    rst_n = 1'b0;
    tick();
    check("mr_rst_count", 64'(count), 64'd0);
    check("mr_rst_valid", 64'(out_valid), 64'd0);
    check("mr_rst_in_ready", 64'(in_ready), 64'd0);
    check("mr_rst_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 64'h1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("mr_new_valid", 64'(out_valid), 64'd1);
    check("mr_new_data", 64'(out_data), 64'h1);
    check("mr_new_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) tick();
    out_ready = 1'b0;
    check("mr_after_valid", 64'(out_valid), 64'd0);
    check("mr_after_count", 64'(count), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
